// File: rtl/sbox_share_driver.sv
// Share-splitting front end for a masked 4-bit sbox: masks each accepted nibble with PRNG output,
// tracks results through the sbox latency, recombines them into a credit-controlled output FIFO.
module sbox_share_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SBOX_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  out_data_o,
  input  logic        seed_load_i,
  input  logic [63:0] seed_fresh_i,
  input  logic [15:0] seed_mask_i,
  output logic [3:0]  x_s0_o,
  output logic [3:0]  x_s1_o,
  output logic [63:0] fresh_o,
  input  logic [3:0]  y_s0_i,
  input  logic [3:0]  y_s1_i
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned PipeW = SBOX_LAT + 1;

  localparam logic [63:0] FreshRst = 64'h0123_4567_89AB_CDEF;
  localparam logic [15:0] MaskRst  = 16'hACE1;

  logic [63:0]      fresh_q, fresh_d;
  logic [15:0]      mask_q, mask_d;
  logic [3:0]       x_s0_q, x_s0_d, x_s1_q, x_s1_d;
  logic [PipeW-1:0] pipe_q, pipe_d;
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [3:0]       mem_q [FIFO_DEPTH];

  logic             accept, push, pop;
  int unsigned      in_flight;

  // Results still inside the sbox already hold a FIFO slot, so the sbox never needs to stall.
  always_comb begin
    in_flight = 0;
    for (int i = 0; i < PipeW; i++) in_flight += 32'(pipe_q[i]);
  end

  assign in_ready_o  = (in_flight + 32'(count_q)) < FIFO_DEPTH;
  assign accept      = in_valid_i & in_ready_o;
  assign push        = pipe_q[PipeW-1];
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign out_data_o  = mem_q[rptr_q];
  assign x_s0_o      = x_s0_q;
  assign x_s1_o      = x_s1_q;
  assign fresh_o     = fresh_q;

  always_comb begin
    fresh_d = {fresh_q[62:0], fresh_q[63] ^ fresh_q[62] ^ fresh_q[60] ^ fresh_q[59]};
    mask_d  = mask_q;
    if (accept) mask_d = {mask_q[14:0], mask_q[15] ^ mask_q[14] ^ mask_q[12] ^ mask_q[3]};
    // Mask for a coincident accept was taken from the pre-load state above.
    if (seed_load_i) begin
      fresh_d = (seed_fresh_i == '0) ? FreshRst : seed_fresh_i;
      mask_d  = (seed_mask_i == '0) ? MaskRst : seed_mask_i;
    end
  end

  always_comb begin
    x_s0_d = x_s0_q;
    x_s1_d = x_s1_q;
    if (accept) begin
      x_s1_d = mask_q[3:0];
      x_s0_d = in_data_i ^ mask_q[3:0];
    end
    if (PipeW > 1) pipe_d = {pipe_q[PipeW-2:0], accept};
    else           pipe_d = accept;
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fresh_q <= FreshRst;
      mask_q  <= MaskRst;
      x_s0_q  <= '0;
      x_s1_q  <= '0;
      pipe_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      fresh_q <= fresh_d;
      mask_q  <= mask_d;
      x_s0_q  <= x_s0_d;
      x_s1_q  <= x_s1_d;
      pipe_q  <= pipe_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // The only place the shares are ever recombined.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= y_s0_i ^ y_s1_i;
  end

endmodule

// File: tb/tb_sbox_share_driver.sv
// Randomised scoreboard bench for sbox_share_driver with a behavioural two-stage masked sbox
// attached; a reference model tracks PRNGs, shares, credit and result order.
module tb_sbox_share_driver;

  localparam int unsigned Depth = 4;
  localparam int unsigned Lat   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0, in_ready_o;
  logic [3:0]  in_data_i = '0;
  logic        out_valid_o, out_ready_i = 1'b0;
  logic [3:0]  out_data_o;
  logic        seed_load_i = 1'b0;
  logic [63:0] seed_fresh_i = '0;
  logic [15:0] seed_mask_i = '0;
  logic [3:0]  x_s0_o, x_s1_o, y_s0_i, y_s1_i;
  logic [63:0] fresh_o;

  sbox_share_driver #(.FIFO_DEPTH(Depth), .SBOX_LAT(Lat)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .seed_load_i  (seed_load_i),
    .seed_fresh_i (seed_fresh_i),
    .seed_mask_i  (seed_mask_i),
    .x_s0_o       (x_s0_o),
    .x_s1_o       (x_s1_o),
    .fresh_o      (fresh_o),
    .y_s0_i       (y_s0_i),
    .y_s1_i       (y_s1_i)
  );

  always #5 clk = ~clk;

  logic [3:0] sbox_t [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                              4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

  // Attached sbox: two register stages, output re-masked with fresh randomness.
  logic [3:0] a1, b1, a2, b2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1 <= '0; b1 <= '0; a2 <= '0; b2 <= '0;
    end else begin
      a1 <= sbox_t[x_s0_o ^ x_s1_o] ^ fresh_o[3:0];
      b1 <= fresh_o[3:0];
      a2 <= a1;
      b2 <= b1;
    end
  end
  assign y_s0_i = a2;
  assign y_s1_i = b2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lfsr_step(input logic [63:0] s, input int w);
    int taps[4];
    logic fb = 1'b0;
    if (w == 64) taps = '{64, 63, 61, 60};
    else         taps = '{16, 15, 13, 4};
    foreach (taps[i]) fb ^= s[taps[i]-1];
    return ((s << 1) | 64'(fb)) & ((w == 64) ? '1 : 64'hFFFF);
  endfunction

  typedef struct {
    logic [3:0] d;
    int         rdy;
  } exp_t;

  exp_t        q[$];
  logic [63:0] fresh_m, fresh_prev;
  logic [63:0] mask_m;
  logic [3:0]  x0_m, x1_m;
  bit          fresh_ok = 0;
  int          n = 0;
  int          n_acc = 0;
  int          hist[16];

  // Scoreboard: compares DUT state to the model, pops on output, pushes on accept.
  always @(negedge clk) begin
    n++;
    if (rst) begin
      fresh_m  = 64'h0123_4567_89AB_CDEF;
      mask_m   = 64'hACE1;
      x0_m     = '0;
      x1_m     = '0;
      fresh_ok = 0;
      q.delete();
    end else begin
      chk("fresh", fresh_o, fresh_m);
      if (fresh_ok) chk("fresh_repeat", 64'(fresh_o != fresh_prev), 64'd1);
      chk("x_s0", 64'(x_s0_o), 64'(x0_m));
      chk("x_s1", 64'(x_s1_o), 64'(x1_m));
      chk("in_ready", 64'(in_ready_o), 64'(q.size() < Depth));
      chk("out_valid", 64'(out_valid_o), 64'(q.size() > 0 && q[0].rdy <= n));
      if (out_valid_o && out_ready_i) begin
        if (q.size() == 0) chk("pop_empty", 64'd1, 64'd0);
        else begin
          chk("out_data", 64'(out_data_o), 64'(q[0].d));
          void'(q.pop_front());
        end
      end
      fresh_prev = fresh_o;
      fresh_ok   = !seed_load_i;
      if (in_valid_i && in_ready_o) begin
        q.push_back('{d: sbox_t[in_data_i], rdy: n + Lat + 2});
        x1_m = mask_m[3:0];
        x0_m = in_data_i ^ mask_m[3:0];
        hist[mask_m[3:0]]++;
        n_acc++;
        mask_m = lfsr_step(mask_m, 16);
      end
      fresh_m = lfsr_step(fresh_m, 64);
      if (seed_load_i) begin
        fresh_m = (seed_fresh_i == '0) ? 64'h0123_4567_89AB_CDEF : seed_fresh_i;
        mask_m  = (seed_mask_i == '0) ? 64'hACE1 : 64'(seed_mask_i);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid_i = 1'b0;
    seed_load_i = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_fresh", fresh_o, 64'h0123_4567_89AB_CDEF);
  endtask

  initial begin
    int acc;
    cyc();
    do_reset();

    // First accept after reset uses the low nibble of the mask reset value.
    in_valid_i = 1'b1; in_data_i = 4'h5; out_ready_i = 1'b1;
    cyc();
    in_valid_i = 1'b0;
    chk("first_x_s1", 64'(x_s1_o), 64'h1);
    chk("first_x_s0", 64'(x_s0_o), 64'h4);
    repeat (6) cyc();

    // 0..F back to back; first result three edges after the first accept.
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 4'(i);
      cyc();
      if (i == 2) chk("lat_not_yet", 64'(out_valid_o), 64'd0);
      if (i == 3) begin
        chk("lat_valid", 64'(out_valid_o), 64'd1);
        chk("lat_data", 64'(out_data_o), 64'hC);
      end
    end
    in_valid_i = 1'b0;
    repeat (8) cyc();

    // Backpressure: credit allows exactly Depth outstanding nibbles.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_data_i = 4'($urandom);
      if (in_ready_o) acc++;
      cyc();
    end
    chk("bp_accepts", 64'(acc), 64'(Depth));
    chk("bp_stalled", 64'(in_ready_o), 64'd0);
    out_ready_i = 1'b1;
    repeat (12) begin in_data_i = 4'($urandom); cyc(); end
    in_valid_i = 1'b0;
    repeat (8) cyc();

    // Zero seeds fall back to the reset constants.
    seed_load_i = 1'b1; seed_fresh_i = '0; seed_mask_i = '0;
    cyc();
    seed_load_i = 1'b0;
    chk("seed0_fresh", fresh_o, 64'h0123_4567_89AB_CDEF);
    in_valid_i = 1'b1; in_data_i = 4'h5;
    cyc();
    in_valid_i = 1'b0;
    chk("seed0_mask", 64'(x_s1_o), 64'h1);
    repeat (6) cyc();

    // Reset with results both buffered and in flight: nothing stale may emerge.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    repeat (5) begin in_data_i = 4'($urandom); cyc(); end
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_idle", 64'(out_valid_o), 64'd0);
      cyc();
    end

    // Random traffic with occasional reseeding.
    for (int i = 0; i < 14000; i++) begin
      in_valid_i  = ($urandom_range(3) != 0);
      in_data_i   = 4'($urandom);
      out_ready_i = ($urandom_range(2) != 0);
      seed_load_i = ($urandom_range(499) == 0);
      seed_fresh_i = ($urandom_range(3) == 0) ? '0 : {$urandom, $urandom};
      seed_mask_i  = ($urandom_range(3) == 0) ? '0 : 16'($urandom);
      cyc();
    end
    seed_load_i = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (20) cyc();
    chk("drain_empty", 64'(q.size()), 64'd0);
    for (int v = 0; v < 16; v++) chk("mask_hist", 64'(hist[v] > n_acc / 32), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
